rotation_angle_tracker: RTL and testbench

Converts the debounced IR beam-break pulse, which fires once per revolution, into the current angular slice index `dtheta` for the frame manager. It measures the clock count of each revolution and divides it into `ROTATIONAL_RES` equal slices. It then advances `dtheta` through the slices and restarts at 0 on every beam-break. It sits between the IR debouncer and the frame manager, on the system clock.

---
 rtl/rotation_angle_tracker_pkg.sv | 21 ++
 rtl/rotation_angle_tracker_period_meter.sv | 74 +++++++
 rtl/rotation_angle_tracker.sv | 146 ++++++++++++++
 tb/tb_rotation_angle_tracker.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotation_angle_tracker_pkg.sv
// -----------------------------------------------------------------------------
// rotation_pkg
// Shared types and helpers for the rotation angle tracker.
//   rot_state_t : tracker state (IDLE / ACQUIRE / LOCKED)
//   rot_log2    : log2 of the slices-per-revolution parameter, usable in
//                 localparam expressions
// -----------------------------------------------------------------------------
package rotation_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } rot_state_t;

   // Callers pass a power of two, so the ceiling log2 is exact.
   function automatic int unsigned rot_log2(input int unsigned res);
      return $clog2(res);
   endfunction

endpackage

// File: rtl/rotation_angle_tracker_period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
// Measures the revolution length from the debounced beam-break level.
// Ports:
//   clk_in      system clock
//   rst_in_n    asynchronous active-low reset
//   ir_tripped  debounced beam-break level, synchronous to clk_in
//   edge_ok     rising edge that is far enough from the last accepted one
//   timeout     revolution counter has saturated at MAX_PERIOD
//   period      length of the last accepted revolution in cycles
// -----------------------------------------------------------------------------
module period_meter #(
   parameter int unsigned PERIOD_WIDTH = 24,
   parameter int unsigned MIN_PERIOD   = 4096,
   parameter int unsigned MAX_PERIOD   = (1 << 24) - 1
) (
   input  logic                    clk_in,
   input  logic                    rst_in_n,
   input  logic                    ir_tripped,
   output logic                    edge_ok,
   output logic                    timeout,
   output logic [PERIOD_WIDTH-1:0] period
);

   localparam logic [PERIOD_WIDTH:0]   MIN_LEN = (PERIOD_WIDTH + 1)'(MIN_PERIOD);
   localparam logic [PERIOD_WIDTH-1:0] MAX_CNT = PERIOD_WIDTH'(MAX_PERIOD);

   logic                    prev_q,    prev_d;
   logic [PERIOD_WIDTH-1:0] per_cnt_q, per_cnt_d;
   logic [PERIOD_WIDTH-1:0] period_q,  period_d;
   logic [PERIOD_WIDTH:0]   cnt_len;
   logic                    rise;

   // NOTE: every signal assigned here gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      prev_d    = ir_tripped;
      per_cnt_d = per_cnt_q;
      period_d  = period_q;

      // One extra bit: with MAX_PERIOD at full scale, per_cnt + 1 overflows.
      cnt_len = {1'b0, per_cnt_q} + (PERIOD_WIDTH + 1)'(1);
      rise    = ir_tripped & ~prev_q;
      edge_ok = rise & (cnt_len >= MIN_LEN);
      timeout = (per_cnt_q == MAX_CNT);

      if (edge_ok) begin
         per_cnt_d = '0;
         // An edge after a full-scale stall would measure 2^PERIOD_WIDTH;
         // clamp it so period never reads back as a tiny value.
         period_d  = cnt_len[PERIOD_WIDTH] ? '1 : cnt_len[PERIOD_WIDTH-1:0];
      end else if (!timeout) begin
         per_cnt_d = per_cnt_q + PERIOD_WIDTH'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         // High so a level already asserted at reset release is not an edge.
         prev_q    <= 1'b1;
         per_cnt_q <= '0;
         period_q  <= '0;
      end else begin
         prev_q    <= prev_d;
         per_cnt_q <= per_cnt_d;
         period_q  <= period_d;
      end
   end

   assign period = period_q;

endmodule

// File: rtl/rotation_angle_tracker.sv
// -----------------------------------------------------------------------------
// rotation_angle_tracker
// Turns the once-per-revolution beam-break into an angular slice index. Each
// accepted revolution length is split into ROTATIONAL_RES equal slices and
// dtheta walks through them, restarting at 0 on every accepted edge.
// Ports:
//   clk_in      system clock
//   rst_in_n    asynchronous active-low reset
//   ir_tripped  debounced beam-break level, synchronous to clk_in
//   dtheta      current slice index (0 outside LOCKED)
//   theta_step  one-cycle pulse whenever dtheta takes a new value
//   locked      period estimate valid, dtheta meaningful
//   period      last accepted revolution length in cycles
// -----------------------------------------------------------------------------
module rotation_angle_tracker
   import rotation_pkg::*;
#(
   parameter int unsigned ROTATIONAL_RES = 1024,
   parameter int unsigned PERIOD_WIDTH   = 24,
   parameter int unsigned MIN_PERIOD     = 4096,
   parameter int unsigned MAX_PERIOD     = (1 << 24) - 1
) (
   input  logic                              clk_in,
   input  logic                              rst_in_n,
   input  logic                              ir_tripped,
   output logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
   output logic                              theta_step,
   output logic                              locked,
   output logic [PERIOD_WIDTH-1:0]           period
);

   localparam int unsigned         LOG2_RES   = rot_log2(ROTATIONAL_RES);
   localparam int unsigned         SLICE_W    = PERIOD_WIDTH - LOG2_RES;
   localparam logic [LOG2_RES-1:0] DTHETA_MAX = LOG2_RES'(ROTATIONAL_RES - 1);

   logic                edge_ok;
   logic                timeout;
   logic [SLICE_W-1:0]  slice_len;
   logic [SLICE_W-1:0]  slice_last;

   rot_state_t          state_q,      state_d;
   logic [SLICE_W-1:0]  slice_cnt_q,  slice_cnt_d;
   logic [LOG2_RES-1:0] dtheta_q,     dtheta_d;
   logic                theta_step_q, theta_step_d;
   logic                locked_q,     locked_d;

   period_meter #(
      .PERIOD_WIDTH (PERIOD_WIDTH),
      .MIN_PERIOD   (MIN_PERIOD),
      .MAX_PERIOD   (MAX_PERIOD)
   ) u_period_meter (
      .clk_in     (clk_in),
      .rst_in_n   (rst_in_n),
      .ir_tripped (ir_tripped),
      .edge_ok    (edge_ok),
      .timeout    (timeout),
      .period     (period)
   );

   // period is captured on the same edge that would capture slice_len, so the
   // truncated slice length is simply its upper bits. MIN_PERIOD >= RES keeps
   // it non-zero once locked; the remainder lands in the last slice.
   assign slice_len  = period[PERIOD_WIDTH-1:LOG2_RES];
   assign slice_last = slice_len - SLICE_W'(1);

   always_comb begin
      state_d      = state_q;
      slice_cnt_d  = slice_cnt_q;
      dtheta_d     = dtheta_q;
      theta_step_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            dtheta_d    = '0;
            slice_cnt_d = '0;
            if (edge_ok) begin
               state_d = ACQUIRE;
            end
         end

         ACQUIRE: begin
            dtheta_d    = '0;
            slice_cnt_d = '0;
            // The edge closes the first full revolution: lock and restart at 0.
            // An edge coinciding with timeout still measured a valid revolution.
            if (edge_ok) begin
               state_d      = LOCKED;
               theta_step_d = 1'b1;
            end else if (timeout) begin
               state_d = IDLE;
            end
         end

         LOCKED: begin
            // Priority: edge restart, then motor-stopped timeout, then slicing.
            if (edge_ok) begin
               dtheta_d     = '0;
               slice_cnt_d  = '0;
               theta_step_d = 1'b1;
            end else if (timeout) begin
               state_d     = IDLE;
               dtheta_d    = '0;
               slice_cnt_d = '0;
            end else if (slice_cnt_q == slice_last) begin
               slice_cnt_d = '0;
               // Saturate at the last slice; no step when the value cannot change.
               if (dtheta_q != DTHETA_MAX) begin
                  dtheta_d     = dtheta_q + LOG2_RES'(1);
                  theta_step_d = 1'b1;
               end
            end else begin
               slice_cnt_d = slice_cnt_q + SLICE_W'(1);
            end
         end

         default: begin
            state_d     = IDLE;
            dtheta_d    = '0;
            slice_cnt_d = '0;
         end
      endcase

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state_q      <= IDLE;
         slice_cnt_q  <= '0;
         dtheta_q     <= '0;
         theta_step_q <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         slice_cnt_q  <= slice_cnt_d;
         dtheta_q     <= dtheta_d;
         theta_step_q <= theta_step_d;
         locked_q     <= locked_d;
      end
   end

   assign dtheta     = dtheta_q;
   assign theta_step = theta_step_q;
   assign locked     = locked_q;

endmodule

// File: tb/tb_rotation_angle_tracker.sv
// -----------------------------------------------------------------------------
// tb_rotation_angle_tracker
// Scoreboard bench. The stimulus process feeds a behavioural model (elapsed
// time since the last accepted edge, dtheta = elapsed / slice_len clamped) and
// queues the output event it predicts for each cycle. The monitor watches the
// DUT and pops an entry whenever theta_step pulses, dtheta changes or locked
// changes, comparing cycle stamp and all outputs.
// -----------------------------------------------------------------------------
module tb_rotation_angle_tracker;

   localparam int RES  = 16;
   localparam int PW   = 12;
   localparam int MINP = 64;
   localparam int MAXP = 4095;
   localparam int PMAX = (1 << PW) - 1;
   localparam int DW   = $clog2(RES);

   logic          clk_in     = 1'b0;
   logic          rst_in_n   = 1'b0;
   logic          ir_tripped = 1'b0;
   logic [DW-1:0] dtheta;
   logic          theta_step;
   logic          locked;
   logic [PW-1:0] period;

   rotation_angle_tracker #(
      .ROTATIONAL_RES (RES),
      .PERIOD_WIDTH   (PW),
      .MIN_PERIOD     (MINP),
      .MAX_PERIOD     (MAXP)
   ) dut (
      .clk_in     (clk_in),
      .rst_in_n   (rst_in_n),
      .ir_tripped (ir_tripped),
      .dtheta     (dtheta),
      .theta_step (theta_step),
      .locked     (locked),
      .period     (period)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc = cyc + 1;

   int total_checks = 0;
   int bad_checks   = 0;

   task automatic check(input string name, input int act, input int exp);
      total_checks++;
      if (act != exp) begin
         bad_checks++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int stamp;
      int dtheta;
      int step;
      int locked;
      int period;
   } exp_t;

   exp_t sb_q[$];

   int m_state;       // 0 idle, 1 acquiring, 2 locked
   int m_base;        // first cycle counted in the current revolution
   bit m_prev;
   int m_period;
   int m_slice;
   int m_lock_start;  // cycle in which dtheta is visibly 0 after the restart
   int e_dtheta;      // last predicted visible outputs
   int e_locked;

   task automatic model_reset();
      m_state  = 0;
      m_period = 0;
      m_slice  = 1;
      e_dtheta = 0;
      e_locked = 0;
      sb_q.delete();
   endtask

   // Input 'ir' is present during cycle c; predicts outputs visible in c+1.
   task automatic model_cycle(input bit ir);
      int   c;
      int   elapsed;
      bit   acc;
      int   nd;
      int   nl;
      bit   step;
      exp_t e;
      c       = cyc;
      elapsed = c - m_base;
      if (elapsed > MAXP) elapsed = MAXP;
      acc    = ir && !m_prev && (elapsed + 1 >= MINP);
      m_prev = ir;
      if (acc) begin
         m_period = (elapsed + 1 > PMAX) ? PMAX : elapsed + 1;
         m_base   = c + 1;
      end
      case (m_state)
         0: if (acc) m_state = 1;
         default: begin
            if (acc) begin
               m_state      = 2;
               m_slice      = m_period / RES;
               m_lock_start = c + 1;
            end else if (elapsed == MAXP) begin
               m_state = 0;
            end
         end
      endcase
      nl = (m_state == 2) ? 1 : 0;
      if (nl == 0) begin
         nd = 0;
      end else begin
         nd = (c + 1 - m_lock_start) / m_slice;
         if (nd > RES - 1) nd = RES - 1;
      end
      step = (nl == 1) && (acc || nd != e_dtheta);
      if (step || nl != e_locked || nd != e_dtheta) begin
         e.stamp  = c + 1;
         e.dtheta = nd;
         e.step   = int'(step);
         e.locked = nl;
         e.period = m_period;
         sb_q.push_back(e);
      end
      e_dtheta = nd;
      e_locked = nl;
   endtask

   // ---------------- monitor ----------------
   int   mp_dtheta = 0;
   logic mp_locked = 1'b0;
   exp_t mon_e;

   always @(negedge clk_in) begin
      if (!rst_in_n) begin
         mp_dtheta = 0;
         mp_locked = 1'b0;
      end else begin
         while (sb_q.size() > 0 && sb_q[0].stamp < cyc) begin
            check("missed_event_cycle", cyc, sb_q[0].stamp);
            void'(sb_q.pop_front());
         end
         if (theta_step || locked != mp_locked || int'(dtheta) != mp_dtheta) begin
            if (sb_q.size() == 0) begin
               check("unexpected_event_cycle", cyc, -1);
            end else begin
               mon_e = sb_q.pop_front();
               check("event_cycle",  cyc,              mon_e.stamp);
               check("event_dtheta", int'(dtheta),     mon_e.dtheta);
               check("event_step",   int'(theta_step), mon_e.step);
               check("event_locked", int'(locked),     mon_e.locked);
               check("event_period", int'(period),     mon_e.period);
            end
         end
         mp_dtheta = int'(dtheta);
         mp_locked = locked;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input bit ir);
      @(negedge clk_in);
      ir_tripped = ir;
      model_cycle(ir);
   endtask

   task automatic idle(input int n, input bit level);
      for (int i = 0; i < n; i++) tick(level);
   endtask

   // Rising edge at the first cycle, held high for w cycles, low for the rest.
   task automatic revolve(input int p, input int w);
      for (int i = 0; i < p; i++) tick(i < w);
   endtask

   // Outputs right after the next clock edge, against the model's view.
   task automatic check_now(input string tag);
      @(posedge clk_in);
      #1;
      check({tag, "_period"}, int'(period), m_period);
      check({tag, "_locked"}, int'(locked), (m_state == 2) ? 1 : 0);
      check({tag, "_dtheta"}, int'(dtheta), e_dtheta);
   endtask

   // Asynchronous reset placed mid-cycle; outputs must clear before any clock.
   task automatic do_reset(input bit ir_level, input int hold);
      @(posedge clk_in);
      #2;
      rst_in_n   = 1'b0;
      ir_tripped = ir_level;
      #1;
      check("rst_dtheta", int'(dtheta),     0);
      check("rst_step",   int'(theta_step), 0);
      check("rst_locked", int'(locked),     0);
      check("rst_period", int'(period),     0);
      model_reset();
      repeat (hold) @(posedge clk_in);
      #2;
      rst_in_n = 1'b1;
      m_base   = cyc;
      m_prev   = 1'b1;
   endtask

   task automatic random_phase(input int n);
      int p;
      int w;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 7) == 0) p = $urandom_range(5, 63);
         else                           p = $urandom_range(64, 700);
         w = $urandom_range(1, 4);
         revolve(p, w);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      model_reset();

      // Lock-up at 320: locked one cycle after the second edge, 20-cycle steps.
      do_reset(1'b0, 3);
      idle(100, 1'b0);
      for (int i = 0; i < 4; i++) revolve(320, 1);
      check_now("lockup");

      // 330 cycles: slice_len 20, dtheta parks at 15 for 30 cycles.
      for (int i = 0; i < 3; i++) revolve(330, 2);
      check_now("trunc");

      // Glitch 40 cycles after a valid edge while locked at 320.
      for (int i = 0; i < 2; i++) revolve(320, 1);
      revolve(40, 1);
      revolve(280, 1);
      check_now("glitch");
      revolve(320, 1);

      // Timeout: stop edges, then relock with two edges.
      revolve(320, 1);
      idle(4200, 1'b0);
      check_now("timeout");
      for (int i = 0; i < 3; i++) revolve(300, 3);
      check_now("relock");

      // Random periods, pulse widths and glitches.
      random_phase(40);
      check_now("random");

      // Reset mid-revolution, released with the beam already tripped.
      for (int i = 0; i < 2; i++) revolve(320, 1);
      idle(150, 1'b0);
      do_reset(1'b1, 2);
      idle(80, 1'b1);
      check_now("rel_high");
      idle(20, 1'b0);
      for (int i = 0; i < 4; i++) revolve(256, 1);
      check_now("after_rst");

      idle(10, 1'b0);
      repeat (3) @(negedge clk_in);
      #1;
      check("sb_drain", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
